// File: rtl/hdmi_video_timing_if.sv
// Video timing bundle between the timing generator and its consumers
// (pixel source, TMDS encoders).
//   master : driven by hdmi_video_timing
//   slave  : pixel source / encoder side
// Signals:
//   x, y         stage-0 column/line counters (CW bits)
//   fetch        stage-0 "pixel is visible" request for the pixel source
//   line_start   stage-0 strobe, x == 0
//   frame_start  stage-0 strobe, x == 0 && y == 0
//   de           fetch delayed by the pipeline depth
//   hsync, vsync delayed, polarity-adjusted syncs
//   frame_cnt    completed-frame counter (mod 256)
//   rgb          built-in test pattern, only with HDMI_TIMING_TEST_PATTERN_EN
interface hdmi_video_timing_if #(
  parameter int unsigned CW = 12
);
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          fetch;
  logic          line_start;
  logic          frame_start;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic [7:0]    frame_cnt;
`ifdef HDMI_TIMING_TEST_PATTERN_EN
  logic [23:0]   rgb;
`endif

  modport master (
    output x, y, fetch, line_start, frame_start, de, hsync, vsync, frame_cnt
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    , output rgb
`endif
  );

  modport slave (
    input x, y, fetch, line_start, frame_start, de, hsync, vsync, frame_cnt
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    , input rgb
`endif
  );
endinterface

// File: rtl/hdmi_video_timing.sv
// Parametrised video timing generator (pixclk domain).
// Free-running x/y counters give early (stage-0) coordinates to a pixel source;
// de/hsync/vsync are pushed through a PIPE_DELAY-deep register chain so they
// line up with that source's output.
// Ports:
//   pixclk  pixel clock, all logic on rising edge
//   resetn  synchronous active-low reset
//   vt      hdmi_video_timing_if.master (coordinates, strobes, syncs, frame_cnt)
// Optional: define HDMI_TIMING_TEST_PATTERN_EN to add a delayed rgb test
// pattern {x[7:0], y[7:0], frame_cnt} on vt.rgb.
module hdmi_video_timing #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned CW         = 12
) (
  input logic                 pixclk,
  input logic                 resetn,
  hdmi_video_timing_if.master vt
);

  if (PIPE_DELAY < 1 || PIPE_DELAY > 15) begin : g_bad_pipe_delay
    $error("hdmi_video_timing: PIPE_DELAY must be within 1..15");
  end

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] HLast    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HActEnd  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActEnd  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncBeg = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSyncEnd = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VSyncBeg = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncEnd = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam int unsigned   PipeLast = PIPE_DELAY - 1;

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          fetch, hs_raw, vs_raw;

  // Pipeline entry: {fetch, hs_raw, vs_raw}
  logic [2:0] pipe_q [PIPE_DELAY];

  always_comb begin
    x_d         = x_q + CW'(1);
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    if (x_q == HLast) begin
      x_d = '0;
      if (y_q == VLast) begin
        y_d         = '0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        y_d = y_q + CW'(1);
      end
    end
  end

  always_comb begin
    fetch  = (x_q < HActEnd) && (y_q < VActEnd);
    hs_raw = (x_q >= HSyncBeg) && (x_q < HSyncEnd);
    vs_raw = (y_q >= VSyncBeg) && (y_q < VSyncEnd);
  end

  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Clearing the whole chain on reset drops in-flight syncs, so no partial
  // pulse can appear after a mid-frame reset.
  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {fetch, hs_raw, vs_raw};
      for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vt.x           = x_q;
  assign vt.y           = y_q;
  assign vt.fetch       = fetch;
  assign vt.line_start  = (x_q == '0);
  assign vt.frame_start = (x_q == '0) && (y_q == '0);
  assign vt.frame_cnt   = frame_cnt_q;
  assign vt.de          = pipe_q[PipeLast][2];
  assign vt.hsync       = pipe_q[PipeLast][1] ^ ~H_POL;
  assign vt.vsync       = pipe_q[PipeLast][0] ^ ~V_POL;

`ifdef HDMI_TIMING_TEST_PATTERN_EN
  logic [23:0] rgb_q [PIPE_DELAY];
  logic [23:0] rgb_s0;

  always_comb begin
    rgb_s0 = 24'h0;
    if (fetch) rgb_s0 = {x_q[7:0], y_q[7:0], frame_cnt_q};
  end

  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      for (int i = 0; i < PIPE_DELAY; i++) rgb_q[i] <= '0;
    end else begin
      rgb_q[0] <= rgb_s0;
      for (int i = 1; i < PIPE_DELAY; i++) rgb_q[i] <= rgb_q[i-1];
    end
  end

  assign vt.rgb = rgb_q[PipeLast];
`endif

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench: two small-timing instances (H 4/1/2/1, V 3/1/1/1,
// PIPE_DELAY=2) with opposite sync polarities, plus a default-size instance
// for the optional test pattern.
module tb_hdmi_video_timing;

  logic pixclk = 1'b0;
  logic resetn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always #5 pixclk = ~pixclk;

  hdmi_video_timing_if #(.CW(4)) vt_a ();
  hdmi_video_timing_if #(.CW(4)) vt_b ();

  hdmi_video_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(2), .CW(4)
  ) u_dut_a (
    .pixclk(pixclk),
    .resetn(resetn),
    .vt    (vt_a)
  );

  hdmi_video_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(2), .CW(4)
  ) u_dut_b (
    .pixclk(pixclk),
    .resetn(resetn),
    .vt    (vt_b)
  );

`ifdef HDMI_TIMING_TEST_PATTERN_EN
  hdmi_video_timing_if #(.CW(12)) vt_c ();

  hdmi_video_timing u_dut_c (
    .pixclk(pixclk),
    .resetn(resetn),
    .vt    (vt_c)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge pixclk);
    #1;
    cyc += n;
  endtask

  task automatic step_to(input int t);
    step(t - cyc);
  endtask

  // Reference timing for the small config: 8 pixels/line, 6 lines/frame.
  function automatic int px(input int t);
    return (t % 48) % 8;
  endfunction
  function automatic int py(input int t);
    return (t % 48) / 8;
  endfunction
  function automatic bit fetch_m(input int t);
    return (t >= 0) && (px(t) < 4) && (py(t) < 3);
  endfunction
  function automatic bit hs_m(input int t);
    return (t >= 0) && (px(t) == 5 || px(t) == 6);
  endfunction
  function automatic bit vs_m(input int t);
    return (t >= 0) && (py(t) == 4);
  endfunction

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge pixclk);
    #1;
    resetn = 1'b1;
    cyc    = 0;

    // First cycle after reset release: reset values still visible.
    chk("rst_x",           vt_a.x, 0);
    chk("rst_y",           vt_a.y, 0);
    chk("rst_frame_start", vt_a.frame_start, 1);
    chk("rst_line_start",  vt_a.line_start, 1);
    chk("rst_fetch",       vt_a.fetch, 1);
    chk("rst_de",          vt_a.de, 0);
    chk("rst_hsync_hi",    vt_a.hsync, 0);
    chk("rst_vsync_hi",    vt_a.vsync, 0);
    chk("rst_hsync_lo",    vt_b.hsync, 1);
    chk("rst_vsync_lo",    vt_b.vsync, 1);
    chk("rst_frame_cnt",   vt_a.frame_cnt, 0);

    // Two full frames plus a bit, cycle by cycle.
    for (int t = 1; t < 100; t++) begin
      step(1);
      chk("x",           vt_a.x, px(t));
      chk("y",           vt_a.y, py(t));
      chk("fetch",       vt_a.fetch, fetch_m(t));
      chk("line_start",  vt_a.line_start, px(t) == 0);
      chk("frame_start", vt_a.frame_start, px(t) == 0 && py(t) == 0);
      chk("de",          vt_a.de, fetch_m(t - 2));
      chk("hsync_hi",    vt_a.hsync, hs_m(t - 2));
      chk("vsync_hi",    vt_a.vsync, vs_m(t - 2));
      chk("hsync_lo",    vt_b.hsync, !hs_m(t - 2));
      chk("vsync_lo",    vt_b.vsync, !vs_m(t - 2));
      chk("frame_cnt",   vt_a.frame_cnt, t / 48);
    end

    // Hand-picked points of line 0 / line 4.
    step_to(2 * 48 + 5);
    chk("de_last_active", vt_a.de, 1);
    step(1);
    chk("de_after_active", vt_a.de, 0);
    step_to(2 * 48 + 7);
    chk("hsync_first", vt_a.hsync, 1);
    chk("hsync_lo_first", vt_b.hsync, 0);
    step_to(2 * 48 + 9);
    chk("hsync_done", vt_a.hsync, 0);
    step_to(2 * 48 + 4 * 8 + 2);
    chk("vsync_line4", vt_a.vsync, 1);
    chk("vsync_lo_line4", vt_b.vsync, 0);

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    step_to(702);
    chk("rgb_blank", vt_c.rgb, 24'h0);
    chk("de_blank",  vt_c.de, 0);
    step_to(3 * 800 + 17 + 2);
    chk("rgb_px",    vt_c.rgb, 24'h110300);
    chk("de_px",     vt_c.de, 1);
`endif

    // Frame counter wrap after 256 frames.
    step_to(48 * 256 - 1);
    chk("fc_255",      vt_a.frame_cnt, 255);
    chk("wrap_x_last", vt_a.x, 7);
    chk("wrap_y_last", vt_a.y, 5);
    step(1);
    chk("fc_wrap",     vt_a.frame_cnt, 0);
    chk("fs_wrap",     vt_a.frame_start, 1);
    chk("wrap_x",      vt_a.x, 0);
    chk("wrap_y",      vt_a.y, 0);

    // Mid-frame reset at x=5, y=2 of frame 1 (after the wrap).
    step(48 + 21);
    chk("pre_rst_x",  vt_a.x, 5);
    chk("pre_rst_y",  vt_a.y, 2);
    chk("pre_rst_fc", vt_a.frame_cnt, 1);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    chk("mid_rst_x",     vt_a.x, 0);
    chk("mid_rst_y",     vt_a.y, 0);
    chk("mid_rst_de",    vt_a.de, 0);
    chk("mid_rst_hs",    vt_a.hsync, 0);
    chk("mid_rst_vs",    vt_a.vsync, 0);
    chk("mid_rst_hs_lo", vt_b.hsync, 1);
    chk("mid_rst_fc",    vt_a.frame_cnt, 0);
    step(1);
    chk("mid_rst1_x",  vt_a.x, 1);
    chk("mid_rst1_de", vt_a.de, 0);
    chk("mid_rst1_hs", vt_a.hsync, 0);
    step(1);
    chk("mid_rst2_x",  vt_a.x, 2);
    chk("mid_rst2_de", vt_a.de, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
